// File: rtl/sram_responder.sv
// Clocked stand-in for an async SRAM: writes commit on the strobe edge, reads drive the bus
// READ_LATENCY edges after the request; no backpressure, the controller's strobes pace every access.
module sram_responder #(
    parameter int ADDR_WIDTH   = 18,
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addrBus,
    inout  wire  [DATA_WIDTH-1:0] dataBus,
    input  logic                  memEnable,
    input  logic                  memRead,
    input  logic                  memWrite,
    output logic                  ready,
    output logic                  busy,
    output logic                  conflict,
    output logic [15:0]           readCount,
    output logic [15:0]           writeCount
);

    typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE_HOLD} state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              lat_cnt;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    drive_q;
    logic                    busy_q;
    logic                    conflict_q;
    logic [15:0]             rd_cnt;
    logic [15:0]             wr_cnt;

    logic wr_req, rd_req, both_req, wr_en;

    assign wr_req   = !memEnable && !memWrite &&  memRead;
    assign rd_req   = !memEnable &&  memWrite && !memRead;
    assign both_req = !memEnable && !memWrite && !memRead;
    assign wr_en    = !rst && (state == IDLE) && wr_req;

    // Array kept out of the reset domain so it maps onto block RAM and survives reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[addrBus[DEPTH_LOG2-1:0]] <= dataBus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            lat_cnt    <= 3'd0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            rd_cnt     <= 16'd0;
            wr_cnt     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        wr_cnt <= wr_cnt + 16'd1;
                        state  <= WRITE_HOLD;
                        busy_q <= 1'b1;
                    end else if (rd_req) begin
                        addr_q  <= addrBus;
                        lat_cnt <= LAT_LOAD;
                        state   <= READ_WAIT;
                        busy_q  <= 1'b1;
                    end else if (both_req) begin
                        conflict_q <= 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (memRead || memEnable) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (lat_cnt == 3'd0) begin
                        data_q  <= mem[addr_q[DEPTH_LOG2-1:0]];
                        rd_cnt  <= rd_cnt + 16'd1;
                        state   <= READ_DRIVE;
                        drive_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                READ_DRIVE: begin
                    if (memRead || memEnable) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        drive_q <= 1'b0;
                    end else if (addrBus != addr_q) begin
                        addr_q  <= addrBus;
                        lat_cnt <= LAT_LOAD;
                        state   <= READ_WAIT;
                        drive_q <= 1'b0;
                    end
                end
                WRITE_HOLD: begin
                    if (memWrite || memEnable) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    // A low write strobe from the controller always wins the bus, even mid-read.
    assign ready      = drive_q && memWrite;
    assign dataBus    = ready ? data_q : 'z;
    assign busy       = busy_q;
    assign conflict   = conflict_q;
    assign readCount  = rd_cnt;
    assign writeCount = wr_cnt;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: read results are checked by a scoreboard monitor,
// status and counters inline by the stimulus process.
module tb_sram_responder;
    localparam int L = 2;

    typedef struct {
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] addr_bus = '0;
    wire  [15:0] data_bus;
    logic        mem_en = 1'b1;
    logic        mem_rd = 1'b1;
    logic        mem_wr = 1'b1;
    logic        ready, busy, conflict;
    logic [15:0] rd_count, wr_count;
    logic        drv_en = 1'b0;
    logic [15:0] drv_dat = '0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   exp_rc  = 0;
    int   exp_wc  = 0;
    logic ready_d = 1'b0;
    exp_t sb[$];

    assign data_bus = drv_en ? drv_dat : 'z;

    sram_responder #(
        .ADDR_WIDTH(18), .DATA_WIDTH(16), .DEPTH_LOG2(10), .READ_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .addrBus(addr_bus), .dataBus(data_bus),
        .memEnable(mem_en), .memRead(mem_rd), .memWrite(mem_wr),
        .ready(ready), .busy(busy), .conflict(conflict),
        .readCount(rd_count), .writeCount(wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every fresh assertion of ready must match the oldest outstanding read, in data and in timing.
    always @(negedge clk) begin
        if (ready && !ready_d) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(data_bus), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("read_data", 32'(data_bus), 32'(e.dat));
                check("read_latency_cycle", cyc, e.cyc);
            end
        end
        ready_d = ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mem_en = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1; drv_en = 1'b0;
    endtask

    // Briefly drive zeros: if the DUT is also driving, the resolved bus will not read back as zero.
    task automatic probe_z(input string nm);
        drv_dat = 16'h0000;
        drv_en  = 1'b1;
        #1;
        check(nm, 32'(data_bus), 32'h0);
        drv_en  = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d);
        addr_bus = a; drv_dat = d; drv_en = 1'b1;
        mem_en = 1'b0; mem_wr = 1'b0; mem_rd = 1'b1;
        tick();
        set_idle();
        tick();
        exp_wc++;
    endtask

    task automatic start_read(input logic [17:0] a, input logic [15:0] d);
        addr_bus = a; drv_en = 1'b0;
        mem_en = 1'b0; mem_rd = 1'b0; mem_wr = 1'b1;
        sb.push_back('{d, cyc + 1 + L});
        repeat (L + 1) tick();
        exp_rc++;
    endtask

    task automatic do_read(input logic [17:0] a, input logic [15:0] d);
        start_read(a, d);
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_conflict", 32'(conflict), 32'h0);
        check("reset_read_count", 32'(rd_count), 32'h0);
        check("reset_write_count", 32'(wr_count), 32'h0);
        probe_z("reset_bus_z");

        // Write then read back with exact latency
        do_write(18'h00005, 16'h1234);
        do_read(18'h00005, 16'h1234);
        check("wr_rd_write_count", 32'(wr_count), 32'd1);
        check("wr_rd_read_count", 32'(rd_count), 32'd1);

        // Upper address bits alias onto the 1K array
        do_write(18'h00405, 16'hBEEF);
        do_read(18'h00005, 16'hBEEF);

        // Held write strobe commits once, to the first address only
        do_write(18'h00011, 16'h7777);
        addr_bus = 18'h00010; drv_dat = 16'hC0DE; drv_en = 1'b1;
        mem_en = 1'b0; mem_wr = 1'b0; mem_rd = 1'b1;
        tick();
        addr_bus = 18'h00011; drv_dat = 16'h0BAD;
        repeat (4) tick();
        check("hold_busy", 32'(busy), 32'h1);
        set_idle();
        tick();
        exp_wc++;
        check("hold_write_count", 32'(wr_count), 32'(exp_wc));
        do_read(18'h00010, 16'hC0DE);
        do_read(18'h00011, 16'h7777);

        // Both strobes low: sticky conflict, nothing else happens
        check("pre_conflict", 32'(conflict), 32'h0);
        addr_bus = 18'h00011; mem_en = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        tick();
        check("conflict_set", 32'(conflict), 32'h1);
        check("conflict_busy", 32'(busy), 32'h0);
        probe_z("conflict_bus_z");
        set_idle();
        tick();
        check("conflict_write_count", 32'(wr_count), 32'(exp_wc));
        check("conflict_read_count", 32'(rd_count), 32'(exp_rc));
        do_read(18'h00011, 16'h7777);
        check("conflict_sticky", 32'(conflict), 32'h1);

        // Address change while driving restarts the read
        do_write(18'h00001, 16'hAAAA);
        do_write(18'h00002, 16'h5555);
        start_read(18'h00001, 16'hAAAA);
        check("drive_ready", 32'(ready), 32'h1);
        check("drive_data", 32'(data_bus), 32'hAAAA);
        addr_bus = 18'h00002;
        sb.push_back('{16'h5555, cyc + 1 + L});
        tick();
        check("readdr_ready_drop", 32'(ready), 32'h0);
        repeat (L) tick();
        exp_rc++;
        check("readdr_ready", 32'(ready), 32'h1);
        set_idle();
        tick();
        check("readdr_read_count", 32'(rd_count), 32'(exp_rc));
        probe_z("read_release_bus_z");

        // Reset while waiting on read latency
        addr_bus = 18'h00002; mem_en = 1'b0; mem_rd = 1'b0; mem_wr = 1'b1;
        tick();
        check("wait_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        check("rst_wait_busy", 32'(busy), 32'h0);
        check("rst_wait_ready", 32'(ready), 32'h0);
        check("rst_wait_read_count", 32'(rd_count), 32'h0);
        check("rst_wait_write_count", 32'(wr_count), 32'h0);
        check("rst_wait_conflict", 32'(conflict), 32'h0);
        probe_z("rst_wait_bus_z");
        rst = 1'b0;
        set_idle();
        tick();
        exp_rc = 0;
        exp_wc = 0;

        // Reset while driving read data
        start_read(18'h00001, 16'hAAAA);
        check("pre_rst_drive_ready", 32'(ready), 32'h1);
        check("pre_rst_drive_count", 32'(rd_count), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_drive_ready", 32'(ready), 32'h0);
        check("rst_drive_busy", 32'(busy), 32'h0);
        check("rst_drive_read_count", 32'(rd_count), 32'h0);
        probe_z("rst_drive_bus_z");
        rst = 1'b0;
        set_idle();
        tick();

        // Array contents survive reset
        do_read(18'h00005, 16'hBEEF);
        check("post_rst_read_count", 32'(rd_count), 32'd1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Synchronous responder for the external asynchronous-SRAM-style bus driven by the CPU memory controller: 18-bit address, 16-bit bidirectional data, and active-low enable, read (output-enable) and write strobes. It samples the strobes on the system clock and stores writes in an internal word array. Read data is returned on the shared data bus after a configurable latency. It stands in for the board SRAM in simulation and in FPGA builds that use block RAM. It also exposes a ready flag, a conflict flag and access counters for debug.

## Interface
- ADDR_WIDTH, 18, width of addrBus
- DATA_WIDTH, 16, width of dataBus
- DEPTH_LOG2, 10, internal array holds 2^DEPTH_LOG2 words; only addrBus[DEPTH_LOG2-1:0] is decoded (upper bits alias)
- READ_LATENCY, 2, clock edges from read-request sample to data driven; legal range 1..7

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- addrBus  input  ADDR_WIDTH  word address from controller
- dataBus  inout  DATA_WIDTH  shared data; driven only in READ_DRIVE, else high-Z
- memEnable  input  1  chip enable, active low
- memRead  input  1  output enable, active low
- memWrite  input  1  write enable, active low
- ready  output  1  high while read data is valid on dataBus
- busy  output  1  high in any state other than IDLE
- conflict  output  1  sticky: memRead and memWrite sampled low together with memEnable low
- readCount  output  16  completed reads, wraps 0xFFFF→0x0000
- writeCount  output  16  committed writes, wraps 0xFFFF→0x0000

## Operation
- States: IDLE, READ_WAIT, READ_DRIVE, WRITE_HOLD.
- IDLE behaviour on each sampled edge:
  - Write request (memEnable=0, memWrite=0, memRead=1): array[addr low bits] <= dataBus on that edge; writeCount++; go to WRITE_HOLD.
  - Read request (memEnable=0, memRead=0, memWrite=1): latch address, load latency counter with READ_LATENCY-1, go to READ_WAIT.
  - Both strobes low with memEnable=0: set conflict, no write, no drive, stay in IDLE.
  - memEnable=1: ignore both strobes.
- READ_WAIT:
  - Counter 0: load the data register from the array at the latched address, readCount++, go to READ_DRIVE.
  - Otherwise: decrement the counter.
  - memRead or memEnable sampled high: abort to IDLE with no count.
- READ_DRIVE:
  - dataBus = data register and ready=1, gated combinationally by memWrite=1 so the block never contends with a controller write.
  - memRead or memEnable sampled high: go to IDLE.
  - addrBus differs from the latched address while memRead stays low: re-latch the address, reload the counter, go to READ_WAIT; ready drops.
- WRITE_HOLD: stay until memWrite or memEnable is sampled high, then go to IDLE. A held strobe commits exactly one write; a changing address during the hold is ignored.
- A read request in WRITE_HOLD is not honoured until the block returns to IDLE.

## Timing
- Reset values, applied on the edge where rst is sampled high and overriding every other event on that edge:
  - state IDLE; ready, busy, conflict = 0; readCount, writeCount = 0; dataBus high-Z.
  - Array contents are not cleared.
- Reset during READ_DRIVE: dataBus is high-Z and ready is 0 from the reset edge onward.
- Read latency: request sampled at edge E0; READ_DRIVE is entered at edge E(READ_LATENCY); ready and data are valid immediately after that edge.
- The write commits on the sampling edge. A read of the same address requested at the next edge returns the new data.
- busy equals state≠IDLE. ready equals state==READ_DRIVE. conflict stays high until reset.
- dataBus returns to high-Z immediately after the edge that leaves READ_DRIVE.

## Test plan
- Write then read, READ_LATENCY=2: write 0x1234 to 0x00005, release the strobe, request a read of 0x00005 at E0. Required: ready=1 and dataBus=0x1234 after E2, not after E1; writeCount=1; readCount=1.
- Aliasing, DEPTH_LOG2=10: write 0xBEEF to 0x00405, then read 0x00005. Required: returns 0xBEEF.
- Held strobe: hold memWrite low for 5 cycles while addrBus changes from 0x10 to 0x11. Required: only array[0x10] is written; writeCount=1.
- Conflict: memEnable=0 with memRead=0 and memWrite=0 at one edge. Required: conflict=1 stays set; dataBus stays Z; array and counters unchanged.
- Address change in READ_DRIVE: read 0x01 (data 0xAAAA), then switch to 0x02 (data 0x5555) with memRead held low. Required: ready drops for READ_LATENCY edges, then 0x5555 is driven; readCount=2.
- Reset mid-read: assert rst during READ_WAIT and during READ_DRIVE. Required: the next state is IDLE, dataBus is Z and all counters are 0.
